// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one 8-lane DRAM port between two requesters; request->dram_en 2 cycles, last lane->ri_valid 1 cycle.
// No backpressure: one pending slot per requester, a request arriving while its slot is busy is dropped and flagged in err.
module dram_arbiter #(
  parameter int LANES = 8,
  parameter int AW    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANES-1:0]      r0_en,
  input  logic                  r0_rdwr,
  input  logic [LANES*AW-1:0]   r0_addr,
  input  logic [LANES*8-1:0]    r0_wdata,
  output logic [LANES-1:0]      r0_valid,
  output logic [LANES*8-1:0]    r0_data,
  input  logic [LANES-1:0]      r1_en,
  input  logic                  r1_rdwr,
  input  logic [LANES*AW-1:0]   r1_addr,
  input  logic [LANES*8-1:0]    r1_wdata,
  output logic [LANES-1:0]      r1_valid,
  output logic [LANES*8-1:0]    r1_data,
  output logic [LANES-1:0]      dram_en,
  output logic                  dram_rdwr,
  output logic [LANES*AW-1:0]   dram_addr,
  output logic [LANES*8-1:0]    dram_wdata,
  input  logic [LANES-1:0]      dram_valid,
  input  logic [LANES*8-1:0]    dram_data,
  output logic                  busy,
  output logic [1:0]            err
);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_WAIT = 1'b1;

  logic [0:0]           state;
  logic                 owner;
  logic                 last_grant;
  logic [1:0]           pend;
  logic [LANES-1:0]     slot_mask  [2];
  logic [1:0]           slot_rdwr;
  logic [LANES*AW-1:0]  slot_addr  [2];
  logic [LANES*8-1:0]   slot_wdata [2];
  logic [LANES-1:0]     mask;
  logic [LANES-1:0]     collected;
  logic [LANES*8-1:0]   rbuf;

  logic [LANES-1:0]     req_en    [2];
  logic [1:0]           req_rdwr;
  logic [LANES*AW-1:0]  req_addr  [2];
  logic [LANES*8-1:0]   req_wdata [2];

  logic                 gnt_vld;
  logic                 gnt_id;
  logic [LANES-1:0]     new_lanes;
  logic [LANES*8-1:0]   rbuf_nxt;
  logic                 done;

  always_comb begin
    req_en[0]    = r0_en;
    req_en[1]    = r1_en;
    req_rdwr     = {r1_rdwr, r0_rdwr};
    req_addr[0]  = r0_addr;
    req_addr[1]  = r1_addr;
    req_wdata[0] = r0_wdata;
    req_wdata[1] = r1_wdata;
  end

  // Only first arrival of each masked lane counts; the buffer is cleared at grant so unmasked bytes read as 0.
  always_comb begin
    gnt_vld   = (state == STATE_IDLE) && (pend != 2'b00);
    gnt_id    = (pend == 2'b11) ? ~last_grant : pend[1];
    new_lanes = (state == STATE_WAIT) ? (dram_valid & mask & ~collected) : '0;
    rbuf_nxt  = rbuf;
    for (int l = 0; l < LANES; l++) begin
      if (new_lanes[l]) rbuf_nxt[l*8 +: 8] = dram_data[l*8 +: 8];
    end
    done = (state == STATE_WAIT) && ((collected | new_lanes) == mask);
  end

  assign busy = (pend != 2'b00) || (state == STATE_WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= STATE_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      pend       <= 2'b00;
      slot_rdwr  <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        slot_mask[i]  <= '0;
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
      end
      mask       <= '0;
      collected  <= '0;
      rbuf       <= '0;
      dram_en    <= '0;
      dram_rdwr  <= 1'b1;
      dram_addr  <= '0;
      dram_wdata <= '0;
      r0_valid   <= '0;
      r0_data    <= '0;
      r1_valid   <= '0;
      r1_data    <= '0;
      err        <= 2'b00;
    end else begin
      dram_en  <= '0;
      r0_valid <= '0;
      r1_valid <= '0;

      // A slot stays pending until its transaction completes, which also covers the in-flight case.
      for (int i = 0; i < 2; i++) begin
        if (req_en[i] != '0) begin
          if (pend[i]) begin
            err[i] <= 1'b1;
          end else begin
            pend[i]       <= 1'b1;
            slot_mask[i]  <= req_en[i];
            slot_rdwr[i]  <= req_rdwr[i];
            slot_addr[i]  <= req_addr[i];
            slot_wdata[i] <= req_wdata[i];
          end
        end
      end

      if (gnt_vld) begin
        dram_en    <= slot_mask[gnt_id];
        dram_rdwr  <= slot_rdwr[gnt_id];
        dram_addr  <= slot_addr[gnt_id];
        dram_wdata <= slot_wdata[gnt_id];
        owner      <= gnt_id;
        last_grant <= gnt_id;
        mask       <= slot_mask[gnt_id];
        collected  <= '0;
        rbuf       <= '0;
        state      <= STATE_WAIT;
      end

      if (state == STATE_WAIT) begin
        collected <= collected | new_lanes;
        rbuf      <= rbuf_nxt;
        if (done) begin
          state       <= STATE_IDLE;
          pend[owner] <= 1'b0;
          if (owner) begin
            r1_valid <= mask;
            r1_data  <= rbuf_nxt;
          end else begin
            r0_valid <= mask;
            r0_data  <= rbuf_nxt;
          end
        end
      end
    end
  end

endmodule
